// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/accumulate controller: one full-adder cell adds two WIDTH-bit operands
// LSB-first, one bit per clock, and registers the sum and carry-out.
//
// state | meaning
// IDLE  | waiting for start; clear is honoured here
// SHIFT | one operand bit pair per edge through the full adder
// DONE  | sum/cout freshly valid, done pulsed for this one cycle
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] res_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    fulladder u_fa (
        .a  (shift_a[0]),
        .b  (shift_b[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !clear) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Both outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        sum  <= '0;
                        cout <= 1'b0;
                    end else if (start) begin
                        shift_a <= acc_mode ? sum : op_a;
                        shift_b <= op_b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
                    carry_q <= fa_co;
                    shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    // Publish the result only once the MSB is in, so sum never shows partials.
                    if (last_bit) begin
                        sum  <= {fa_s, res_sr[WIDTH-1:1]};
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule
